// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART tx arbiter slice
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY_LOW
    } arb_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int rr_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for a single asynchronous status bit
module sync_bit
    import uart_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
// across NUM_REQ byte requesters with a cross-clock start/busy handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_REQ-1:0]                  reqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       reqData,
    output logic [NUM_REQ-1:0]                  reqReady,
    output logic                                txStart,
    output logic [DATA_WIDTH-1:0]               txData,
    input  logic                                txBusy,
    output logic [rr_idx_width(NUM_REQ)-1:0]    grantId,
    output logic                                sendDone,
    output logic                                timeoutErr
);

    localparam int IDW  = rr_idx_width(NUM_REQ);
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CNTW-1:0] r_cnt;
    logic            w_busy_s;
    logic            w_accept;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_next_ptr;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_busy_sync (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_d    (txBusy),
        .o_q    (w_busy_s)
    );

    // First pending requester at or above ptr, wrapping past NUM_REQ-1.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] idx;
        logic           found;
        rr_pick = ptr;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
            idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
        end
    endfunction

    assign w_gnt_idx  = rr_pick(reqValid, r_rr_ptr);
    assign w_next_ptr = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
    assign w_accept   = rstn && (r_state == ST_IDLE) && !w_busy_s && (reqValid != '0);
    assign reqReady   = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            txStart    <= 1'b0;
            txData     <= '0;
            grantId    <= '0;
            sendDone   <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            sendDone   <= 1'b0;
            timeoutErr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        txData   <= reqData[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        grantId  <= w_gnt_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_cnt    <= '0;
                        txStart  <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    // Busy takes precedence over an expiring timeout.
                    if (w_busy_s) begin
                        txStart <= 1'b0;
                        r_state <= ST_WAIT_BUSY_LOW;
                    end else if (r_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
                        txStart    <= 1'b0;
                        timeoutErr <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                ST_WAIT_BUSY_LOW: begin
                    if (!w_busy_s) begin
                        sendDone <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    txStart <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin controller that shares one UART transmitter among NUM_REQ byte requesters.
- Runs on the board clock `clk`. The transmitter runs on the baud-rate `txClk` from the baud generator.
- Sequences the transmitter's start/busy handshake across that clock boundary: holds start until busy is seen, then waits for busy to clear.
- Sits between the command/telemetry sources and the UART tx serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, byte width per request.
- SYNC_STAGES, 2, flops in the txBusy synchronizer (at least 2).
- TIMEOUT_CYCLES, 65535, clk cycles allowed in START for busy to rise (at least 2 txClk periods at default rates).

Ports:
- clk  in  1  board clock (CLOCK_RATE domain).
- rstn  in  1  asynchronous active-low reset.
- reqValid  in  NUM_REQ  bit i: requester i has a byte pending; held until reqReady[i].
- reqData  in  NUM_REQ*DATA_WIDTH  requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqReady  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i accepted.
- txStart  out  1  level request to the transmitter; held until synced busy is high.
- txData  out  DATA_WIDTH  byte to send; stable from START entry until return to IDLE.
- txBusy  in  1  transmitter busy, txClk domain; treated as asynchronous.
- grantId  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- sendDone  out  1  1-cycle pulse: transmitter finished the granted byte.
- timeoutErr  out  1  1-cycle pulse: busy never rose within TIMEOUT_CYCLES; byte dropped.

Behaviour:
- Reset (async assert, sync deassert via clk):
  - state=IDLE; txStart=0; txData=0; reqReady=0; grantId=0.
  - sendDone=0; timeoutErr=0; rrPtr=0; timeout counter=0; sync chain all 0.
- Sync: busyS is the SYNC_STAGES-flop synchronized txBusy. Only busyS is used in decisions.
- States: IDLE, START, WAIT_BUSY_LOW.
- IDLE:
  - Leaves only when busyS==0 and reqValid!=0.
  - Round-robin select: first set bit searching upward from rrPtr, wrapping at NUM_REQ-1 to 0.
  - Same cycle: reqReady[g]=1, latch txData=reqData[g], set grantId=g and rrPtr=(g+1) mod NUM_REQ.
  - Next cycle: state=START, txStart=1, counter cleared.
  - Latency: reqValid high to txStart high = 1 cycle when idle and busyS=0.
- START:
  - txStart held at 1; counter increments each cycle.
  - busyS==1: txStart=0 next cycle, go to WAIT_BUSY_LOW.
  - Else, counter==TIMEOUT_CYCLES-1: txStart=0, timeoutErr pulse, go to IDLE. rrPtr is not rolled back.
  - If busy rises on the same cycle as the timeout expires, busy wins (no error).
- WAIT_BUSY_LOW:
  - busyS==0: sendDone pulse, go to IDLE.
  - Re-arbitration is possible on the cycle after sendDone.
- Request behaviour:
  - reqValid dropped by a requester before grant: ignored, no error.
  - reqData is sampled only in the accept cycle.
  - At most one reqReady bit set per cycle; never set outside IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap inside START.
- busyS high in IDLE (e.g. after reset mid-frame): arbiter stalls in IDLE until it clears.
- rstn asserted mid-operation: txStart drops immediately (async); pending byte lost.

Decomposition:
- Shared package `uart_pkg`: state enum (IDLE/START/WAIT_BUSY_LOW), default SYNC_STAGES, helper function for round-robin index width.
- One sub-module `sync_bit` (SYNC_STAGES-deep flop chain, async active-low reset) for txBusy. It is reusable for rx-side status.
- Arbiter priority logic stays inline.

Test Plan:
- Single request, model busy rising 3 cycles after txStart, high 100 cycles:
  - reqValid=4'b0010, reqData[15:8]=8'hA5.
  - Expect reqReady=4'b0010 for 1 cycle, txData=8'hA5, grantId=1.
  - Expect txStart to drop 3+SYNC_STAGES cycles after rising, and sendDone once after busy falls.
- Fairness: reqValid=4'b1111 held, reissued after each accept.
  - Expect grant order 0,1,2,3,0, and no requester granted twice before all others.
- Wrap: rrPtr=3 (after granting 2), reqValid=4'b0101.
  - Expect grant 0, then 2.
- Timeout: TIMEOUT_CYCLES=16, busy tied 0.
  - Expect txStart high exactly 16 cycles, then timeoutErr pulse, IDLE, no sendDone.
- Busy at reset exit: txBusy=1 for 50 cycles after rstn release, reqValid=4'b0001.
  - Expect no reqReady until busyS==0, then grant 0.
- Async reset mid-START: assert rstn=0 while txStart=1.
  - Expect txStart=0 immediately, then all outputs at reset values, and a fresh arbitration from rrPtr=0 after release.
